// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: field widths, the NOP
// encoding used as filler, and the per-cycle operation encoding.
package inst_fetch_queue_pkg;

    localparam int unsigned PC_SIZE_DEFAULT = 32;
    localparam int unsigned INSTR_WIDTH     = 32;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    // What the queue does on a given edge, ignoring flush.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fq_op_e;

    // Combine the qualified push and pop strobes into one operation code.
    function automatic fq_op_e decodeOp(input logic push, input logic pop);
        fq_op_e op;
        op = OP_IDLE;
        case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fq_ptr.sv
// Modulo-DEPTH pointer used for both the head and the tail of the fetch
// queue. Clear wins over increment so a flush always lands on entry 0.
module fq_ptr
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       incr_i,
    output logic [$clog2(DEPTH)-1:0]   ptr_o
);

    localparam int unsigned         PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]    LAST  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer value: clear, wrap from the last entry to 0, or step by one.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (incr_i) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer register, forced to 0 while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers {PC, instruction} pairs between fetch and
// decode. Flush (redirect) empties the queue and drops the presented pair.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned PC_SIZE = PC_SIZE_DEFAULT,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [PC_SIZE-1:0]        in_pc,
    input  logic [31:0]               in_instr,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [PC_SIZE-1:0]        out_pc,
    output logic [31:0]               out_instr,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned        ENTRY_W  = PC_SIZE + INSTR_WIDTH;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] headEntry;

    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               push;
    logic               pop;
    fq_op_e             op;

    // Status depends only on the stored count, never on the handshake inputs.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A full queue refuses new pairs even when the head leaves this cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;
    assign op   = decodeOp(push, pop);

    fq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clock   (clock),
        .reset   (reset),
        .clear_i (flush),
        .incr_i  (pop),
        .ptr_o   (headPtr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clock   (clock),
        .reset   (reset),
        .clear_i (flush),
        .incr_i  (push),
        .ptr_o   (tailPtr)
    );

    // Occupancy update: flush empties, push/pop step, push+pop holds steady.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case (op)
                OP_PUSH: count_d = count_q + ONE_CNT;
                OP_POP:  count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register, emptied asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; stale contents are hidden by out_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tailPtr] <= {in_pc, in_instr};
        end
    end

    // Present the head entry, zeroed when the queue holds nothing.
    always_comb begin
        headEntry = mem_q[headPtr];
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = headEntry[INSTR_WIDTH +: PC_SIZE];
            out_instr = headEntry[INSTR_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic, checked
// at every falling edge against a queue-based model of the FIFO contents.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int PC_SIZE = 32;
    localparam int DEPTH   = 4;

    logic                   clock;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic [PC_SIZE-1:0]     in_pc;
    logic [31:0]            in_instr;
    logic                   in_ready;
    logic                   out_valid;
    logic [PC_SIZE-1:0]     out_pc;
    logic [31:0]            out_instr;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    int checks;
    int failures;
    bit simDone;

    // Expected queue contents, oldest first: {pc, instr}.
    logic [63:0] expQ[$];

    inst_fetch_queue #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    // Monitor and model: compare the DUT against the expected queue, then
    // advance the model by what the coming rising edge will do.
    initial begin
        int   sz;
        logic doPush;
        logic doPop;
        while (!simDone) begin
            @(negedge clock);
            if (!reset) begin
                expQ.delete();
            end
            sz = expQ.size();
            checkOutput("count", 64'(count), 64'(sz));
            checkOutput("in_ready", 64'(in_ready), 64'(sz != DEPTH));
            checkOutput("out_valid", 64'(out_valid), 64'(sz != 0));
            if (sz > 0) begin
                checkOutput("out_pc", 64'(out_pc), 64'(expQ[0][63:32]));
                checkOutput("out_instr", 64'(out_instr), 64'(expQ[0][31:0]));
            end else begin
                checkOutput("out_pc_empty", 64'(out_pc), 64'd0);
                checkOutput("out_instr_empty", 64'(out_instr), 64'd0);
            end
            if (reset) begin
                if (flush) begin
                    expQ.delete();
                end else begin
                    doPush = in_valid && (sz != DEPTH);
                    doPop  = out_ready && (sz != 0);
                    if (doPop) void'(expQ.pop_front());
                    if (doPush) expQ.push_back({in_pc, in_instr});
                end
            end
        end
    end

    initial begin
        simDone   = 1'b0;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;

        @(posedge clock);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_count", 64'(count), 64'd0);
        reset = 1'b1;

        // Fill to full without consuming; first push lands on the first edge after release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("full_count", 64'(count), 64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("full_head_instr", 64'(out_instr), 64'hA0);

        // Full queue: pop PC 0 while PC 4 is presented and must be refused.
        applyStimulus(1'b1, 32'd4, 32'hA4, 1'b1, 1'b0);
        checkOutput("after_pop_count", 64'(count), 64'd3);
        checkOutput("after_pop_head", 64'(out_pc), 64'd1);
        applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b0, 1'b0);

        // Drain.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);

        // Stream 10 pairs with both sides always ready.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
            checkOutput("stream_count_le1", 64'(count <= 1), 64'd1);
        end
        applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);

        // Three entries, then flush against a push and a pop.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h20 + 32'(i), NOP_INSTR, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 32'hDEAD, 1'b1, 1'b1);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);

        // Two entries, then asynchronous reset between edges.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h60 + 32'(i), NOP_INSTR, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_in_ready", 64'(in_ready), 64'd1);
        checkOutput("async_out_pc", 64'(out_pc), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 32'h80, 32'h0080_0013, 1'b0, 1'b0);
        checkOutput("post_reset_pc", 64'(out_pc), 64'h80);
        applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);

        // Consume attempts on an empty queue, then confirm order is intact.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h90, 32'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h94, 32'h5678, 1'b0, 1'b0);
        checkOutput("empty_pop_head", 64'(out_pc), 64'h90);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(),
                          ($urandom_range(0, 3) == 0) ? NOP_INSTR : $urandom(),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, NOP_INSTR, 1'b1, 1'b0);

        simDone = 1'b1;
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
